// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The queue takes the slave modport; fetch/decode (or a bench) takes master.
interface if_id_queue_if #(
  parameter int XLEN  = 32,
  parameter int PTR_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm16;
  logic [25:0]     out_instr_index;
  logic [PTR_W:0]  count;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_instr_index, count
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_instr_index, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FIFO of {pc, instr} pairs between
// fetch and decode, with flush on redirect and MIPS field pre-split of the head.
// Optional feature macro: BUF_BYPASS_EN -- when defined, an empty queue passes
// a fetched pair straight to decode in the same cycle if decode is ready.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int XLEN  = 32
) (
  input logic         CLK,
  input logic         RST_N,
  if_id_queue_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic   full, empty, bypass, push, pop;
  entry_t head, out_e;

  // Handshake qualification; flush kills both push and pop.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
`ifdef BUF_BYPASS_EN
    bypass = empty & bus.in_valid & bus.out_ready & ~bus.flush;
`else
    bypass = 1'b0;
`endif
    // A bypassed pair is consumed directly, never written.
    push = bus.in_valid & ~full & ~bus.flush & ~bypass;
    pop  = ~empty & bus.out_ready & ~bus.flush;
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: bus.in_pc, instr: bus.in_instr};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state with synchronous reset; reset discards contents like flush.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated whenever the queue is empty.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  // Head presentation: gated to zero (NOP) when empty so no X reaches decode.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (bypass)      out_e = '{pc: bus.in_pc, instr: bus.in_instr};
    else if (!empty) out_e = head;
    else             out_e = '0;
    bus.in_ready        = ~full;
    bus.out_valid       = ~empty | bypass;
    bus.out_pc          = out_e.pc;
    bus.out_instr       = out_e.instr;
    bus.out_opcode      = out_e.instr[31:26];
    bus.out_rs          = out_e.instr[25:21];
    bus.out_rt          = out_e.instr[20:16];
    bus.out_rd          = out_e.instr[15:11];
    bus.out_shamt       = out_e.instr[10:6];
    bus.out_funct       = out_e.instr[5:0];
    bus.out_imm16       = out_e.instr[15:0];
    bus.out_instr_index = out_e.instr[25:0];
    bus.count           = count_q;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: the driver pushes expected pairs as they
// are accepted, a monitor pops and compares on every decode handshake.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int XLEN  = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  if_id_queue_if #(.XLEN(XLEN), .PTR_W(PTR_W)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .XLEN(XLEN)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int miss = 0;
  logic [63:0] exp_q[$];
  int   mcnt = 0;
  logic mon_en = 1'b0;
  logic cur_iv, cur_ordy, cur_fl, cur_rst, cur_acc, cur_pop, cur_byp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at negedge and compute what the queue should accept this cycle.
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic rst = 1'b1);
    @(negedge CLK);
    RST_N = rst; bus.in_valid = iv; bus.in_pc = pc; bus.in_instr = ins;
    bus.out_ready = ordy; bus.flush = fl;
    cur_iv = iv; cur_ordy = ordy; cur_fl = fl; cur_rst = rst;
`ifdef BUF_BYPASS_EN
    cur_byp = rst && iv && ordy && !fl && (mcnt == 0);
`else
    cur_byp = 1'b0;
`endif
    cur_acc = rst && iv && !fl && !cur_byp && (mcnt < DEPTH);
    cur_pop = rst && ordy && !fl && (mcnt > 0);
    if (cur_acc || cur_byp) exp_q.push_back({pc, ins});
    #3;
  endtask

  // Advance the model past the posedge and check occupancy-derived outputs.
  task automatic tick();
    logic exp_ov;
    @(posedge CLK);
    if (!cur_rst || cur_fl) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      mcnt = mcnt + (cur_acc ? 1 : 0) - (cur_pop ? 1 : 0);
    end
    #1;
    exp_ov = (mcnt != 0);
`ifdef BUF_BYPASS_EN
    if (mcnt == 0 && cur_iv && cur_ordy && !cur_fl && cur_rst) exp_ov = 1'b1;
`endif
    check("count", 32'(bus.count), 32'(mcnt));
    check("in_ready", 32'(bus.in_ready), 32'(mcnt != DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (!exp_ov) begin
      check("empty_instr", bus.out_instr, 32'h0);
      check("empty_pc", bus.out_pc, 32'h0);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl, input logic rst = 1'b1);
    drive(iv, pc, ins, ordy, fl, rst);
    tick();
  endtask

  // Monitor: compares every consumed head against the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (mon_en && RST_N && bus.out_valid && bus.out_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", bus.out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", bus.out_pc, e[63:32]);
          check("pop_instr", bus.out_instr, e[31:0]);
          check("pop_opcode", 32'(bus.out_opcode), 32'(e[31:26]));
          check("pop_rs", 32'(bus.out_rs), 32'(e[25:21]));
          check("pop_rt", 32'(bus.out_rt), 32'(e[20:16]));
          check("pop_rd", 32'(bus.out_rd), 32'(e[15:11]));
          check("pop_shamt", 32'(bus.out_shamt), 32'(e[10:6]));
          check("pop_funct", 32'(bus.out_funct), 32'(e[5:0]));
          check("pop_imm16", 32'(bus.out_imm16), 32'(e[15:0]));
          check("pop_index", 32'(bus.out_instr_index), 32'(e[25:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset held two cycles with fetch presenting a pair.
    step(1'b1, 32'h4, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 32'hA1, 1'b0, 1'b0, 1'b0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    mon_en = 1'b1;

    // Fill, overflow attempt, full-with-pop ignores input, then drain.
    step(1'b1, 32'h4,  32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'h8,  32'hA2, 1'b0, 1'b0);
    step(1'b1, 32'hC,  32'hA3, 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
    check("full_count", 32'(bus.count), 32'h4);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    step(1'b1, 32'h14, 32'hA5, 1'b0, 1'b0);
    check("overflow_count", 32'(bus.count), 32'h4);
    step(1'b1, 32'h18, 32'hA6, 1'b1, 1'b0);
    check("full_pop_count", 32'(bus.count), 32'h3);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("drained_count", 32'(bus.count), 32'h0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("underflow_count", 32'(bus.count), 32'h0);

    // Streaming at count=2 across pointer wrap.
    step(1'b1, 32'h100, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 32'hB1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h108 + 32'(4*i), 32'hC0 + 32'(i), 1'b1, 1'b0);
    check("stream_count", 32'(bus.count), 32'h2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush at count=3 with push and pop requested.
    step(1'b1, 32'h200, 32'hD0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 32'h208, 32'hD2, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD0, 32'hDEAD, 1'b1, 1'b1);
    check("flush_count", 32'(bus.count), 32'h0);
    check("flush_out_valid", 32'(bus.out_valid), 32'h0);
    check("flush_out_instr", bus.out_instr, 32'h0);
    step(1'b1, 32'h20C, 32'hD3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Field split of add $8,$9,$10.
    step(1'b1, 32'h300, 32'h012A4020, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("f_opcode", 32'(bus.out_opcode), 32'h0);
    check("f_rs", 32'(bus.out_rs), 32'd9);
    check("f_rt", 32'(bus.out_rt), 32'd10);
    check("f_rd", 32'(bus.out_rd), 32'd8);
    check("f_shamt", 32'(bus.out_shamt), 32'h0);
    check("f_funct", 32'(bus.out_funct), 32'h20);
    check("f_imm16", 32'(bus.out_imm16), 32'h4020);
    check("f_index", 32'(bus.out_instr_index), 32'h012A4020);
    tick();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue with fetch and decode both ready.
    drive(1'b1, 32'h40, 32'h1234, 1'b1, 1'b0);
`ifdef BUF_BYPASS_EN
    check("byp_out_valid", 32'(bus.out_valid), 32'h1);
    check("byp_out_pc", bus.out_pc, 32'h40);
    tick();
    check("byp_count", 32'(bus.count), 32'h0);
`else
    check("nobyp_out_valid", 32'(bus.out_valid), 32'h0);
    tick();
    check("nobyp_count", 32'(bus.count), 32'h1);
    check("nobyp_out_pc", bus.out_pc, 32'h40);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream discards contents.
    step(1'b1, 32'h500, 32'hE0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 32'hE1, 1'b0, 1'b0);
    step(1'b1, 32'h508, 32'hE2, 1'b1, 1'b0, 1'b0);
    check("midrst_count", 32'(bus.count), 32'h0);
    step(1'b1, 32'h50C, 32'hE3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
